// File: rtl/rf_param.sv
// Parameterised register file with two combinational read ports, optional write
// forwarding, optional hard-wired zero register, a flags register and a sequential clear engine.
module rf_param #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int FLAG_W  = 5,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              flags_wr_en,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] flags_out,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] count;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              addr_zero_locked;
    logic              write_ok;

    assign busy = (state == CLEAR);

    // A write to the hard-wired zero register is dropped and must never be forwarded.
    assign addr_zero_locked = (ZERO_R0 != 0) && (wr_addr == '0);
    assign write_ok         = wr_en && !busy && !addr_zero_locked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        count <= '0;
                    end
                end
                CLEAR: begin
                    count <= count + 1'b1;
                    if (count == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[count] <= '0;
        end else if (write_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Flags are wiped only on the first clear cycle; later clear cycles leave them at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_out <= '0;
        end else if (busy) begin
            if (count == '0) begin
                flags_out <= '0;
            end
        end else if (flags_wr_en) begin
            flags_out <= flags_in;
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if ((ZERO_R0 != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if ((BYPASS != 0) && write_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if ((ZERO_R0 != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if ((BYPASS != 0) && write_ok && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param: two instances (forwarding on / zero-r0 with no forwarding)
// driven in lockstep and compared against a behavioural model of the register file.
module tb_rf_param;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic        flags_wr_en;
    logic [4:0]  flags_in;
    logic        clr_req;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [4:0]  a_flags, b_flags;
    logic        a_busy, b_busy;

    int compared;
    int mismatched;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [4:0]  m_flags;
    logic        m_busy;
    int          m_idx;

    rf_param dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_rd1), .rd_data2(a_rd2),
        .flags_wr_en(flags_wr_en), .flags_in(flags_in), .flags_out(a_flags),
        .clr_req(clr_req), .busy(a_busy)
    );

    rf_param #(.BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_rd1), .rd_data2(b_rd2),
        .flags_wr_en(flags_wr_en), .flags_in(flags_in), .flags_out(b_flags),
        .clr_req(clr_req), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] exp_a(input logic [3:0] addr);
        if (!m_busy && !reset && wr_en && addr == wr_addr) return wr_data;
        return mem_a[addr];
    endfunction

    function automatic logic [15:0] exp_b(input logic [3:0] addr);
        if (addr == 4'd0) return 16'd0;
        return mem_b[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        m_flags = '0;
        m_busy  = 1'b0;
        m_idx   = 0;
    endtask

    // One rising edge of the reference register file, using the inputs held across that edge.
    task automatic model_edge();
        if (m_busy) begin
            mem_a[m_idx] = '0;
            mem_b[m_idx] = '0;
            if (m_idx == 0) m_flags = '0;
            m_idx++;
            if (m_idx == 16) m_busy = 1'b0;
        end else begin
            if (wr_en) begin
                mem_a[wr_addr] = wr_data;
                if (wr_addr != 4'd0) mem_b[wr_addr] = wr_data;
            end
            if (flags_wr_en) m_flags = flags_in;
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic checkOutput();
        chk("a_rd1", a_rd1, exp_a(rd_addr1));
        chk("a_rd2", a_rd2, exp_a(rd_addr2));
        chk("b_rd1", b_rd1, exp_b(rd_addr1));
        chk("b_rd2", b_rd2, exp_b(rd_addr2));
        chk("a_flags", a_flags, m_flags);
        chk("b_flags", b_flags, m_flags);
        chk("a_busy", a_busy, m_busy);
        chk("b_busy", b_busy, m_busy);
    endtask

    // Inputs are set at the falling edge; outputs checked just after, model advanced at the rising edge.
    task automatic applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_busy", a_busy, 1'b0);
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_en = 0; flags_wr_en = 0; clr_req = 0;
        wr_addr = 0; wr_data = 0; flags_in = 0;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
        idle_inputs();
        wr_en = 1; wr_addr = addr; wr_data = data;
        applyStimulus();
        wr_en = 0;
    endtask

    task automatic check_all_zero(input string tag);
        idle_inputs();
        for (int i = 0; i < 16; i += 2) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(i + 1);
            #1;
            chk({tag, "_rd1"}, a_rd1, 16'd0);
            chk({tag, "_rd2"}, a_rd2, 16'd0);
            applyStimulus();
        end
        chk({tag, "_flags"}, a_flags, 5'd0);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) write_reg(4'(i), 16'(i * 16'h0111 + 1));
    endtask

    int n;

    initial begin
        compared = 0;
        mismatched = 0;
        model_reset();
        idle_inputs();
        rd_addr1 = 0; rd_addr2 = 0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_rd1", a_rd1, 16'd0);
        chk("rst_flags", a_flags, 5'd0);
        chk("rst_busy", a_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read on both ports; disabled write leaves r6 alone.
        write_reg(4'd5, 16'd1000);
        rd_addr1 = 5; rd_addr2 = 5;
        #1;
        chk("r5_p1", a_rd1, 16'd1000);
        chk("r5_p2", a_rd2, 16'd1000);
        applyStimulus();
        wr_en = 0; wr_addr = 6; wr_data = 77; rd_addr1 = 6;
        applyStimulus();
        #1;
        chk("r6_kept", a_rd1, 16'd0);

        // Forwarding: instance A sees new data before the edge, instance B the old value.
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rd_addr1 = 3;
        #1;
        chk("byp_on", a_rd1, 16'hBEEF);
        chk("byp_off_old", b_rd1, 16'd0);
        applyStimulus();
        wr_en = 0;
        #1;
        chk("byp_off_new", b_rd1, 16'hBEEF);

        // Zero register on instance B.
        write_reg(4'd0, 16'h1234);
        write_reg(4'd1, 16'h55AA);
        rd_addr1 = 0; rd_addr2 = 1;
        #1;
        chk("r0_zero", b_rd1, 16'd0);
        chk("r0_plain", a_rd1, 16'h1234);
        chk("r1_norm", b_rd2, 16'h55AA);
        applyStimulus();

        // Full clear: busy exactly 16 cycles, ignored writes and requests while busy.
        fill_all();
        flags_wr_en = 1; flags_in = 5'b10101;
        applyStimulus();
        idle_inputs();
        #1;
        chk("flags_set", a_flags, 5'b10101);
        clr_req = 1;
        applyStimulus();
        n = 0;
        while (a_busy && n < 40) begin
            wr_en = 1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 16'hFFFF;
            flags_wr_en = 1; flags_in = 5'b11111; clr_req = 1;
            rd_addr1 = 4'($urandom_range(0, 15)); rd_addr2 = 4'($urandom_range(0, 15));
            applyStimulus();
            n++;
        end
        chk("busy_len", n, 16);
        check_all_zero("clr");

        // Reset in the middle of a clear sequence.
        fill_all();
        idle_inputs();
        clr_req = 1;
        applyStimulus();
        clr_req = 0;
        for (int i = 0; i < 7; i++) applyStimulus();
        apply_reset();
        chk("abort_busy", a_busy, 1'b0);
        check_all_zero("abort");
        chk("abort_idle", a_busy, 1'b0);

        // Flags write coinciding with a clear request.
        idle_inputs();
        flags_wr_en = 1; flags_in = 5'b00011; clr_req = 1;
        applyStimulus();
        idle_inputs();
        #1;
        chk("flags_pre_clr", a_flags, 5'b00011);
        applyStimulus();
        #1;
        chk("flags_post_clr", a_flags, 5'd0);
        n = 0;
        while (a_busy && n < 40) begin
            applyStimulus();
            n++;
        end
        chk("busy_rest", n, 15);

        // Randomised traffic, with occasional clears and resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end else begin
                wr_en       = 1'($urandom_range(0, 1));
                wr_addr     = 4'($urandom_range(0, 15));
                wr_data     = 16'($urandom);
                rd_addr1    = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
                rd_addr2    = 4'($urandom_range(0, 15));
                flags_wr_en = 1'($urandom_range(0, 1));
                flags_in    = 5'($urandom);
                clr_req     = ($urandom_range(0, 39) == 0);
                applyStimulus();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL expose parameter FLAG_W, default 5, processor status flag width.
REQ-004 The block SHALL expose parameter BYPASS, default 1, enabling write-to-read forwarding when 1.
REQ-005 The block SHALL expose parameter ZERO_R0, default 0, making register 0 read-only zero when 1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  register write enable.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 rd_addr1  input  ADDR_W  read port 1 address.
REQ-012 rd_addr2  input  ADDR_W  read port 2 address.
REQ-013 rd_data1  output  WIDTH  read port 1 data.
REQ-014 rd_data2  output  WIDTH  read port 2 data.
REQ-015 flags_wr_en  input  1  flags register write enable.
REQ-016 flags_in  input  FLAG_W  new flag values.
REQ-017 flags_out  output  FLAG_W  current flags register.
REQ-018 clr_req  input  1  request to zero the whole register file.
REQ-019 busy  output  1  high while a clear sequence runs.

Function
REQ-020 Reads SHALL be combinational from the array; both ports independent, same address on both ports allowed.
REQ-021 A write SHALL update register wr_addr on the rising edge when wr_en=1 and busy=0; wr_en=0 leaves the array unchanged.
REQ-022 With BYPASS=1, wr_en=1, busy=0 and rd_addrN==wr_addr, rd_dataN SHALL equal wr_data in the same cycle; with BYPASS=0 it SHALL show the old contents.
REQ-023 With ZERO_R0=1, reads of address 0 SHALL return 0, writes to address 0 SHALL be dropped, and address 0 SHALL NOT be bypassed.
REQ-024 flags_out SHALL load flags_in on the rising edge when flags_wr_en=1 and busy=0; otherwise it holds.
REQ-025 The controller SHALL have two states, IDLE (busy=0) and CLEAR (busy=1).
REQ-026 In IDLE, clr_req=1 SHALL move the controller to CLEAR next cycle with the clear counter at 0; a wr_en/flags_wr_en in that same IDLE cycle SHALL still take effect.
REQ-027 In each CLEAR cycle, register[counter] SHALL be written 0 and the counter SHALL increment by 1.
REQ-028 The first CLEAR cycle SHALL also zero flags_out.
REQ-029 When counter==DEPTH-1, the controller SHALL write that register and return to IDLE, so busy is high for exactly DEPTH cycles.
REQ-030 While busy=1, wr_en, flags_wr_en, clr_req and bypass SHALL be ignored; reads SHALL return current array contents.

Reset
REQ-031 reset=1 SHALL asynchronously zero all registers, flags_out and the counter, force IDLE and drive busy=0.
REQ-032 reset asserted mid-CLEAR SHALL abort the sequence immediately; IDLE is resumed on deassertion with no pending clear.

Verification
REQ-033 Write 1000 to r5 with wr_en=1, then read r5 on both ports -> rd_data1=rd_data2=1000; wr_en=0 with wr_data=77 to r6 -> r6 stays 0.
REQ-034 BYPASS=1: wr_en=1, wr_addr=3, wr_data=0xBEEF, rd_addr1=3 -> rd_data1=0xBEEF in the same cycle; BYPASS=0 -> rd_data1 shows the old value until after the edge.
REQ-035 ZERO_R0=1: write 0x1234 to r0 -> rd_data1 for address 0 reads 0; a write to r1 behaves normally.
REQ-036 Fill all 16 registers with nonzero values, set flags=5'b10101, pulse clr_req -> busy high for exactly 16 cycles; all registers and flags read 0 afterwards; wr_en pulses during busy have no effect.
REQ-037 Assert reset at CLEAR cycle 7 with r8-r15 nonzero -> busy=0 immediately, all registers and flags 0, state IDLE after deassertion.
REQ-038 Same cycle: flags_wr_en=1 with flags_in=5'b00011 and clr_req=1 in IDLE -> flags_out=5'b00011 after that edge, then 0 after the first CLEAR cycle.
